mesi_snoop_bus: RTL and testbench
=================================

# mesi_snoop_bus

Central snoopy-bus controller that serves the per-cache MESI controllers: arbitrates their BusRd/BusRdX requests, broadcasts the winning transaction as snoop strobes to every other cache, and collects their hit/flush replies. It then sources the line either from the flushing cache or from memory and returns a shared indication plus completion to the requester. One instance sits between all L1 MESI controllers and the memory port.

## Interface
- `N_CACHES`, default 4: number of attached cache controllers (≥2).
- `MEM_LAT`, default 4: memory read latency in cycles (≥1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; returns every register to its reset value.
- `req_rd` in N_CACHES: per-cache BusRd request, level, held until `done`.
- `req_rdx` in N_CACHES: per-cache BusRdX request, level, held until `done`.
- `snoop_hit` in N_CACHES: cache holds the line in S/E/M; valid during SNOOP.
- `flush_in` in N_CACHES: cache is supplying the line (E/M owner); valid during SNOOP.
- `grant` out N_CACHES: one-hot winner, held from SNOOP through RESP.
- `bus_rd_seen` out N_CACHES: snoop strobe to non-winners, BusRd, SNOOP cycle only.
- `bus_rdx_seen` out N_CACHES: snoop strobe to non-winners, BusRdX, SNOOP cycle only.
- `shared_line` out N_CACHES: to the winner only, valid with `done`.
- `done` out N_CACHES: one-cycle completion pulse to the winner.
- `mem_rd` out 1: one-cycle memory read strobe.
- `mem_wr` out 1: one-cycle memory write-back strobe (flushed data).
- `data_src` out 1: 1 = cache-to-cache, 0 = memory; valid with `done`.
- `err` out 1: sticky; more than one `flush_in` sampled in one SNOOP.

## Operation
- States: IDLE, SNOOP, WB, MEM, RESP.
- IDLE: if any `req_rd|req_rdx` is set, pick the winner round-robin starting at `rr_ptr`. Register `grant`, register op (rdx beats rd when both are set for one cache), then go to SNOOP.
- SNOOP: assert `bus_rd_seen` or `bus_rdx_seen` on all bits except the winner. At the end of the cycle, register:
  - `shared` = OR of `snoop_hit` over non-winners;
  - `flushed` = OR of `flush_in` over non-winners;
  - set `err` if `$countones(flush_in & ~grant) > 1`.
  - Go to WB if `flushed`, else MEM.
- WB: `mem_wr`=1 for one cycle, `data_src`=1, then go to RESP.
- MEM: `mem_rd`=1 in the first cycle only. The down-counter loads MEM_LAT−1; go to RESP when it reaches 0.
- RESP: `done[winner]`=1. `shared_line[winner]` = `shared` for BusRd, 0 for BusRdX. `rr_ptr` ← winner+1 mod N_CACHES, `grant` clears, go to IDLE.
- Winner-side `snoop_hit`/`flush_in` bits are ignored. Non-winner requests stay pending and are not snooped.
- A requester dropping its request mid-transaction does not abort; the transaction completes and `done` still pulses.
- Counter width is `$clog2(MEM_LAT)` (min 1).

## Timing
- Reset values: `grant`, `bus_*_seen`, `shared_line`, `done` all 0. `mem_rd`, `mem_wr`, `data_src`, `err` all 0. State IDLE, `rr_ptr` 0.
- Request sampled in IDLE at cycle t; SNOOP at t+1.
- Flush path: WB at t+2, `done` at t+3.
- Memory path: MEM t+2..t+1+MEM_LAT, `done` at t+2+MEM_LAT.
- Back-to-back: IDLE always occupies one cycle between transactions. Minimum spacing is 4 cycles (flush) or MEM_LAT+3.
- Requests arriving outside IDLE wait; no request is lost while held.
- All outputs are registered or decoded from registered state only; no combinational input→output path.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No `done` is issued for the aborted transaction; `err` clears.

## Structure
- Package `mesi_bus_pkg`:
  - state enum;
  - bus op encoding (BUS_RD, BUS_RDX);
  - MESI state constants I/S/E/M (2-bit), shared with the per-cache controllers.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`; output one-hot `gnt`, combinational.
- Top: FSM, latency counter, snoop-reply registers.

## Test plan
- Single BusRd from cache 0, no hits, MEM_LAT=4 → `bus_rd_seen`=4'b1110 at t+1, `mem_rd` at t+2, `done`=4'b0001 at t+6, `shared_line[0]`=0, `data_src`=0.
- BusRd from cache 1, cache 3 asserts `snoop_hit`+`flush_in` → `mem_wr` at t+2, `done`=4'b0010 at t+3, `shared_line[1]`=1, `data_src`=1.
- BusRdX from cache 2 while caches 0,1 `snoop_hit` → `bus_rdx_seen`=4'b1011, `done[2]` at t+6, `shared_line[2]`=0.
- All four request simultaneously, held → grants in order 0,1,2,3, each `done` exactly once; then cache 0 re-requests after 3 → granted next.
- Caches 0 and 1 both assert `flush_in` for cache 2's BusRd → `err`=1 and stays 1; transaction still completes via WB.
- Assert `reset` during MEM → next cycle state IDLE, all outputs 0; held request re-arbitrated after deassert with `rr_ptr`=0.

Source files
------------

// File: rtl/mesi_bus_pkg.sv
// mesi_bus_pkg: shared types and constants for the snoopy bus and the per-cache MESI controllers
package mesi_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_WB,
        ST_MEM,
        ST_RESP
    } bus_state_t;

    typedef enum logic {
        BUS_RD  = 1'b0,
        BUS_RDX = 1'b1
    } bus_op_t;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, one-hot grant, search starts at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    // walk N slots from ptr with wrap-around and grant the first requester
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_snoop_bus.sv
// mesi_snoop_bus: snoopy-bus controller, arbitrates BusRd/BusRdX, broadcasts snoops, sources the line
module mesi_snoop_bus
    import mesi_bus_pkg::*;
#(
    parameter int N_CACHES = 4,
    parameter int MEM_LAT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CACHES-1:0] req_rd,
    input  logic [N_CACHES-1:0] req_rdx,
    input  logic [N_CACHES-1:0] snoop_hit,
    input  logic [N_CACHES-1:0] flush_in,
    output logic [N_CACHES-1:0] grant,
    output logic [N_CACHES-1:0] bus_rd_seen,
    output logic [N_CACHES-1:0] bus_rdx_seen,
    output logic [N_CACHES-1:0] shared_line,
    output logic [N_CACHES-1:0] done,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                data_src,
    output logic                err
);
    localparam int            PW       = $clog2(N_CACHES);
    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    bus_state_t          state, state_n;
    bus_op_t             op_r;
    logic [N_CACHES-1:0] grant_r, arb_gnt, others;
    logic [PW-1:0]       rr_ptr, win_r, win_n;
    logic [CW-1:0]       cnt;
    logic                shared_r, flushed_r, err_r, req_any;

    assign req_any = |(req_rd | req_rdx);
    assign others  = ~grant_r;

    rr_arbiter #(.N(N_CACHES)) u_arb (
        .req (req_rd | req_rdx),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    // convert the one-hot arbiter result to the winner index used for the pointer update
    always_comb begin
        win_n = '0;
        for (int i = 0; i < N_CACHES; i++)
            if (arb_gnt[i]) win_n = PW'(i);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // next-state: flush replies divert to write-back, otherwise wait out memory latency
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = req_any ? ST_SNOOP : ST_IDLE;
            ST_SNOOP: state_n = |(flush_in & others) ? ST_WB : ST_MEM;
            ST_WB:    state_n = ST_RESP;
            ST_MEM:   state_n = (cnt == '0) ? ST_RESP : ST_MEM;
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // transaction registers: winner, op, snoop replies, latency counter, sticky error, rr pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r   <= '0;
            op_r      <= BUS_RD;
            win_r     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            shared_r  <= 1'b0;
            flushed_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_any) begin
                grant_r <= arb_gnt;
                win_r   <= win_n;
                op_r    <= (|(arb_gnt & req_rdx)) ? BUS_RDX : BUS_RD;
            end
            if (state == ST_SNOOP) begin
                shared_r  <= |(snoop_hit & others);
                flushed_r <= |(flush_in & others);
                cnt       <= CNT_LOAD;
                if ($countones(flush_in & others) > 1) err_r <= 1'b1;
            end
            if (state == ST_MEM && cnt != '0) cnt <= cnt - CW'(1);
            if (state == ST_RESP) begin
                grant_r <= '0;
                rr_ptr  <= (win_r == PW'(N_CACHES - 1)) ? '0 : win_r + PW'(1);
            end
        end
    end

    assign grant        = grant_r;
    assign bus_rd_seen  = (state == ST_SNOOP && op_r == BUS_RD)  ? others : '0;
    assign bus_rdx_seen = (state == ST_SNOOP && op_r == BUS_RDX) ? others : '0;
    assign done         = (state == ST_RESP) ? grant_r : '0;
    assign shared_line  = (state == ST_RESP && op_r == BUS_RD && shared_r) ? grant_r : '0;
    assign mem_rd       = (state == ST_MEM) && (cnt == CNT_LOAD);
    assign mem_wr       = (state == ST_WB);
    assign data_src     = flushed_r && (state == ST_WB || state == ST_RESP);
    assign err          = err_r;

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// tb_mesi_snoop_bus: directed and randomized checks of the snoop bus against a transaction-level model
module tb_mesi_snoop_bus;
    localparam int N   = 4;
    localparam int LAT = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] req_rd = '0, req_rdx = '0, snoop_hit = '0, flush_in = '0;
    logic [N-1:0] grant, bus_rd_seen, bus_rdx_seen, shared_line, done;
    logic         mem_rd, mem_wr, data_src, err;
    logic [23:0]  all_out;

    int vectors = 0, miscompares = 0;
    int m_ptr = 0;
    bit err_m = 1'b0;

    int          o_seen_k, o_mrd_n, o_mrd_k, o_mwr_n, o_mwr_k, o_done_k;
    logic [N-1:0] o_rd_seen, o_rdx_seen, o_gnt, o_done, o_sh;
    logic         o_ds, o_err;
    bit           o_stable;

    mesi_snoop_bus #(.N_CACHES(N), .MEM_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_rdx      (req_rdx),
        .snoop_hit    (snoop_hit),
        .flush_in     (flush_in),
        .grant        (grant),
        .bus_rd_seen  (bus_rd_seen),
        .bus_rdx_seen (bus_rdx_seen),
        .shared_line  (shared_line),
        .done         (done),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .data_src     (data_src),
        .err          (err)
    );

    assign all_out = {grant, bus_rd_seen, bus_rdx_seen, shared_line, done, mem_rd, mem_wr, data_src, err};

    always #5 clk = ~clk;

    // round-robin model: first pending cache at or after the pointer, wrapping
    function automatic int model_winner(logic [N-1:0] p, int ptr);
        for (int j = 0; j < N; j++)
            if (p[(ptr + j) % N]) return (ptr + j) % N;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_rd = '0; req_rdx = '0; snoop_hit = '0; flush_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        err_m = 1'b0;
        @(negedge clk);
    endtask

    // runs one transaction from an IDLE negedge through the following IDLE cycle, recording observations
    task automatic run_txn(input int w, input logic [N-1:0] ar, ax, h, f, input bit inj, drop);
        logic [N-1:0] nr;
        req_rd = req_rd | ar; req_rdx = req_rdx | ax; snoop_hit = h; flush_in = f;
        o_seen_k = -1; o_mrd_n = 0; o_mrd_k = -1; o_mwr_n = 0; o_mwr_k = -1; o_done_k = -1;
        o_rd_seen = '0; o_rdx_seen = '0; o_gnt = '0; o_done = '0; o_sh = '0; o_ds = 0; o_err = 0;
        o_stable = 1'b1;
        for (int k = 1; k <= 40 && o_done_k < 0; k++) begin
            @(negedge clk);
            if (o_seen_k < 0 && (bus_rd_seen | bus_rdx_seen) != '0) begin
                o_seen_k = k; o_rd_seen = bus_rd_seen; o_rdx_seen = bus_rdx_seen; o_gnt = grant;
            end else if (o_seen_k > 0 && grant !== o_gnt) o_stable = 1'b0;
            if (mem_rd === 1'b1) begin o_mrd_n++; o_mrd_k = k; end
            if (mem_wr === 1'b1) begin o_mwr_n++; o_mwr_k = k; end
            if (k == 2 && inj) begin
                nr = N'($urandom) & ~(req_rd | req_rdx);
                req_rd = req_rd | (nr & N'($urandom));
                req_rdx = req_rdx | (nr & ~req_rd);
            end
            if (k == 2 && drop) begin req_rd[w] = 1'b0; req_rdx[w] = 1'b0; end
            if (done != '0) begin
                o_done_k = k; o_done = done; o_sh = shared_line; o_ds = data_src; o_err = err;
            end
        end
        req_rd[w] = 1'b0; req_rdx[w] = 1'b0;
        m_ptr = (w + 1) % N;
        @(negedge clk);
        snoop_hit = '0; flush_in = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (all_out !== 24'h0) begin
            miscompares++; $display("FAIL reset.held: outputs %h, want 000000", all_out);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_out !== 24'h0) begin
            miscompares++; $display("FAIL reset.released: outputs %h, want 000000", all_out);
        end
    endtask

    task automatic test_single_rd();
        run_txn(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vectors++;
        if (o_seen_k != 1 || o_rd_seen !== 4'b1110 || o_rdx_seen !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_rd.snoop: rd %b rdx %b at %0d, want 1110 0000 at 1", o_rd_seen, o_rdx_seen, o_seen_k);
        end
        vectors++;
        if (o_mrd_n != 1 || o_mrd_k != 2 || o_mwr_n != 0) begin
            miscompares++;
            $display("FAIL single_rd.mem: mem_rd x%0d at %0d mem_wr x%0d, want x1 at 2, x0", o_mrd_n, o_mrd_k, o_mwr_n);
        end
        vectors++;
        if (o_done !== 4'b0001 || o_done_k != LAT + 2) begin
            miscompares++; $display("FAIL single_rd.done: %b at %0d, want 0001 at %0d", o_done, o_done_k, LAT + 2);
        end
        vectors++;
        if (o_sh !== 4'b0000 || o_ds !== 1'b0) begin
            miscompares++; $display("FAIL single_rd.resp: shared %b src %b, want 0000 0", o_sh, o_ds);
        end
    endtask

    task automatic test_flush();
        run_txn(1, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 0, 0);
        vectors++;
        if (o_mwr_n != 1 || o_mwr_k != 2 || o_mrd_n != 0) begin
            miscompares++;
            $display("FAIL flush.mem: mem_wr x%0d at %0d mem_rd x%0d, want x1 at 2, x0", o_mwr_n, o_mwr_k, o_mrd_n);
        end
        vectors++;
        if (o_done !== 4'b0010 || o_done_k != 3) begin
            miscompares++; $display("FAIL flush.done: %b at %0d, want 0010 at 3", o_done, o_done_k);
        end
        vectors++;
        if (o_sh !== 4'b0010 || o_ds !== 1'b1) begin
            miscompares++; $display("FAIL flush.resp: shared %b src %b, want 0010 1", o_sh, o_ds);
        end
        vectors++;
        if (o_err !== 1'b0) begin
            miscompares++; $display("FAIL flush.err: %b, want 0", o_err);
        end
    endtask

    task automatic test_rdx();
        run_txn(2, 4'b0000, 4'b0100, 4'b0011, 4'b0000, 0, 0);
        vectors++;
        if (o_seen_k != 1 || o_rdx_seen !== 4'b1011 || o_rd_seen !== 4'b0000) begin
            miscompares++;
            $display("FAIL rdx.snoop: rd %b rdx %b at %0d, want 0000 1011 at 1", o_rd_seen, o_rdx_seen, o_seen_k);
        end
        vectors++;
        if (o_done !== 4'b0100 || o_done_k != LAT + 2) begin
            miscompares++; $display("FAIL rdx.done: %b at %0d, want 0100 at %0d", o_done, o_done_k, LAT + 2);
        end
        vectors++;
        if (o_sh !== 4'b0000 || o_ds !== 1'b0) begin
            miscompares++; $display("FAIL rdx.resp: shared %b src %b, want 0000 0", o_sh, o_ds);
        end
    endtask

    task automatic test_err();
        run_txn(2, 4'b0100, 4'b0000, 4'b0011, 4'b0011, 0, 0);
        vectors++;
        if (o_done !== 4'b0100 || o_done_k != 3 || o_ds !== 1'b1 || o_mwr_n != 1) begin
            miscompares++;
            $display("FAIL err.wb: done %b at %0d src %b mem_wr x%0d, want 0100 at 3 1 x1", o_done, o_done_k, o_ds, o_mwr_n);
        end
        vectors++;
        if (o_err !== 1'b1 || o_sh !== 4'b0100) begin
            miscompares++; $display("FAIL err.set: err %b shared %b, want 1 0100", o_err, o_sh);
        end
        run_txn(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vectors++;
        if (o_err !== 1'b1 || o_done !== 4'b0010 || o_done_k != LAT + 2) begin
            miscompares++;
            $display("FAIL err.sticky: err %b done %b at %0d, want 1 0010 at %0d", o_err, o_done, o_done_k, LAT + 2);
        end
    endtask

    task automatic test_reset_mid();
        req_rd = req_rd | 4'b1001;
        repeat (3) @(negedge clk);
        vectors++;
        if ({grant, err} !== {4'b1000, 1'b1}) begin
            miscompares++; $display("FAIL reset_mid.before: grant %b err %b, want 1000 1", grant, err);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (all_out !== 24'h0) begin
            miscompares++; $display("FAIL reset_mid.async: outputs %h, want 000000", all_out);
        end
        @(negedge clk);
        vectors++;
        if (all_out !== 24'h0) begin
            miscompares++; $display("FAIL reset_mid.held: outputs %h, want 000000", all_out);
        end
        reset = 1'b0;
        m_ptr = 0;
        err_m = 1'b0;
        run_txn(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vectors++;
        if (o_done !== 4'b0001 || o_done_k != LAT + 2 || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid.rearb: done %b at %0d err %b, want 0001 at %0d 0", o_done, o_done_k, o_err, LAT + 2);
        end
        run_txn(3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vectors++;
        if (o_done !== 4'b1000 || o_done_k != LAT + 2) begin
            miscompares++; $display("FAIL reset_mid.pending: done %b at %0d, want 1000 at %0d", o_done, o_done_k, LAT + 2);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(order[i], (i == 0) ? 4'b1111 : (i == 1) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
            vectors++;
            if (o_done !== 4'(1 << order[i]) || o_gnt !== 4'(1 << order[i]) || !o_stable) begin
                miscompares++;
                $display("FAIL rr.grant%0d: grant %b done %b stable %0d, want %b", i, o_gnt, o_done, o_stable, 4'(1 << order[i]));
            end
        end
    endtask

    task automatic test_drop();
        int busy = 0;
        run_txn(m_ptr == 2 ? 2 : 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        vectors++;
        if (o_done !== 4'b0100 || o_done_k != LAT + 2) begin
            miscompares++; $display("FAIL drop.done: %b at %0d, want 0100 at %0d", o_done, o_done_k, LAT + 2);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant != '0 || done != '0) busy++;
        end
        vectors++;
        if (busy != 0) begin
            miscompares++; $display("FAIL drop.idle: %0d busy cycles with no request, want 0", busy);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] nr, ar, ax, h, f, oth, e_rd, e_rdx, e_sh;
        logic [N-1:0] pend_x;
        int w, nfl, e_done_k;
        bit rx, fl, sh;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            nr = N'($urandom) & ~(req_rd | req_rdx);
            if ((req_rd | req_rdx | nr) == '0) nr = N'(1 << $urandom_range(0, N - 1));
            ar = nr & N'($urandom);
            ax = (nr & ~ar) | (nr & N'($urandom));
            h = N'($urandom);
            f = ($urandom_range(0, 7) == 0) ? N'($urandom) :
                ($urandom_range(0, 1) == 1) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            w = model_winner(req_rd | req_rdx | nr, m_ptr);
            pend_x = req_rdx | ax;
            rx = pend_x[w];
            oth = N'(~(1 << w));
            sh = |(h & oth);
            nfl = $countones(f & oth);
            fl = nfl > 0;
            err_m = err_m | (nfl > 1);
            e_rd = rx ? '0 : oth;
            e_rdx = rx ? oth : '0;
            e_sh = (!rx && sh) ? N'(1 << w) : '0;
            e_done_k = fl ? 3 : LAT + 2;
            run_txn(w, ar, ax, h, f, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            vectors++;
            if (o_seen_k != 1 || o_rd_seen !== e_rd || o_rdx_seen !== e_rdx) begin
                miscompares++;
                $display("FAIL rand%0d.snoop: rd %b rdx %b at %0d, want %b %b at 1", it, o_rd_seen, o_rdx_seen, o_seen_k, e_rd, e_rdx);
            end
            vectors++;
            if (o_mrd_n != (fl ? 0 : 1) || o_mwr_n != (fl ? 1 : 0) || (fl ? o_mwr_k : o_mrd_k) != 2) begin
                miscompares++;
                $display("FAIL rand%0d.mem: rd x%0d@%0d wr x%0d@%0d, flush path %0d", it, o_mrd_n, o_mrd_k, o_mwr_n, o_mwr_k, fl);
            end
            vectors++;
            if (o_done !== N'(1 << w) || o_done_k != e_done_k || o_gnt !== N'(1 << w) || !o_stable) begin
                miscompares++;
                $display("FAIL rand%0d.done: %b at %0d grant %b stable %0d, want %b at %0d", it, o_done, o_done_k, o_gnt, o_stable, N'(1 << w), e_done_k);
            end
            vectors++;
            if (o_sh !== e_sh || o_ds !== fl) begin
                miscompares++; $display("FAIL rand%0d.resp: shared %b src %b, want %b %b", it, o_sh, o_ds, e_sh, fl);
            end
            vectors++;
            if (o_err !== err_m) begin
                miscompares++; $display("FAIL rand%0d.err: %b, want %b", it, o_err, err_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rd();
        test_flush();
        test_rdx();
        test_err();
        test_reset_mid();
        test_round_robin();
        test_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
